// File: rtl/vip_char_vertical_segment.sv
// Vertical projection of the plate rows and character column scan.
// Build option CHAR_SEG_OVERLAY_EN adds a box overlay on post_img_Bit.
module vip_char_vertical_segment #(
  parameter logic [9:0] IMG_HDISP = 10'd640,
  parameter logic [9:0] IMG_VDISP = 10'd480,
  parameter logic [9:0] COL_TH    = 10'd2,
  parameter logic [9:0] MIN_W     = 10'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        per_img_Bit,
  input  logic [9:0]  row_top,
  input  logic [9:0]  row_bottom,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        post_img_Bit,
  output logic [3:0]  char_num,
  output logic [79:0] char_left,
  output logic [79:0] char_right,
  output logic        seg_valid,
  output logic        seg_overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nx;

  logic       vs_r, hs_r;
  logic       href_rise, href_fall, vsync_fall;
  logic [9:0] x_cnt, y_cnt;
  logic       first_line, line_block;
  logic [9:0] rt, rb, rt_eff, rb_eff;
  logic       blk_eff, in_rows, issue, go;

  logic [9:0] mem [IMG_HDISP];
  logic [9:0] rd_addr, rd_data, wr_data;
  logic       wr_en_r, bit_r, first_r;
  logic [9:0] x_cnt_r;

  logic [9:0] scan_cnt, col, run_start;
  logic       scan_ok, in_run, eval, on, last;
  logic       close_run, keep;
  logic [9:0] cs, ce, width;
  logic [3:0] cnt;
  logic [7:0][9:0] slot_l, slot_r;

  logic [3:0] v1;
  logic       ov_hit;

  assign href_rise  = per_frame_href & ~hs_r;
  assign href_fall  = ~per_frame_href & hs_r;
  assign vsync_fall = ~per_frame_vsync & vs_r;

  // bounds and block flag take effect on the very first pixel of a line
  assign rt_eff  = (href_rise && first_line) ? row_top : rt;
  assign rb_eff  = (href_rise && first_line) ? row_bottom : rb;
  assign blk_eff = href_rise ? (state == SCAN) : line_block;
  assign in_rows = (y_cnt >= rt_eff) && (y_cnt <= rb_eff);
  assign issue   = per_frame_clken & per_frame_href & in_rows & ~blk_eff;
  assign go      = href_fall && (y_cnt == IMG_VDISP - 10'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_r       <= 1'b0;
      hs_r       <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      first_line <= 1'b1;
      line_block <= 1'b0;
      rt         <= '0;
      rb         <= '0;
      wr_en_r    <= 1'b0;
      x_cnt_r    <= '0;
      bit_r      <= 1'b0;
      first_r    <= 1'b0;
    end else begin
      vs_r <= per_frame_vsync;
      hs_r <= per_frame_href;
      if (href_fall)
        x_cnt <= '0;
      else if (per_frame_clken)
        x_cnt <= x_cnt + 10'd1;
      if (vsync_fall)
        y_cnt <= '0;
      else if (href_fall)
        y_cnt <= y_cnt + 10'd1;
      if (vsync_fall)
        first_line <= 1'b1;
      else if (href_rise)
        first_line <= 1'b0;
      if (href_rise) begin
        line_block <= (state == SCAN);
        rt         <= rt_eff;
        rb         <= rb_eff;
      end
      wr_en_r <= issue;
      x_cnt_r <= x_cnt;
      bit_r   <= per_img_Bit;
      first_r <= (y_cnt == rt_eff);
    end
  end

  assign rd_addr = (state == SCAN) ? scan_cnt : x_cnt;
  assign wr_data = first_r ? {9'd0, bit_r}
                           : rd_data + {9'd0, bit_r};

  always_ff @(posedge clk) begin
    if (rd_addr < IMG_HDISP)
      rd_data <= mem[rd_addr];
    if (wr_en_r)
      mem[x_cnt_r] <= wr_data;
  end

  assign eval = (state == SCAN) && (scan_cnt != 10'd0);
  assign col  = scan_cnt - 10'd1;
  assign on   = scan_ok && (rd_data >= COL_TH);
  assign last = (col == IMG_HDISP - 10'd1);

  always_comb begin
    close_run = 1'b0;
    cs        = run_start;
    ce        = col - 10'd1;
    if (eval) begin
      if (in_run && !on) begin
        close_run = 1'b1;
      end else if (on && last) begin
        close_run = 1'b1;
        cs        = in_run ? run_start : col;
        ce        = col;
      end
    end
  end

  assign width = ce - cs + 10'd1;
  assign keep  = close_run && (width >= MIN_W) && (cnt < 4'd8);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = SCAN;
      SCAN: if (scan_cnt == IMG_HDISP) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      scan_cnt    <= '0;
      scan_ok     <= 1'b0;
      in_run      <= 1'b0;
      run_start   <= '0;
      cnt         <= '0;
      slot_l      <= '0;
      slot_r      <= '0;
      char_num    <= '0;
      char_left   <= '0;
      char_right  <= '0;
      seg_valid   <= 1'b0;
      seg_overrun <= 1'b0;
    end else begin
      state       <= state_nx;
      seg_valid   <= (state == DONE);
      seg_overrun <= href_rise && (state == SCAN);
      if (state == IDLE && go) begin
        scan_cnt <= '0;
        scan_ok  <= (rt <= rb);
        in_run   <= 1'b0;
        cnt      <= '0;
        slot_l   <= '0;
        slot_r   <= '0;
      end else if (state == SCAN) begin
        scan_cnt <= scan_cnt + 10'd1;
        if (eval) begin
          in_run <= on;
          if (on && !in_run)
            run_start <= col;
          if (keep) begin
            slot_l[cnt[2:0]] <= cs;
            slot_r[cnt[2:0]] <= ce;
            cnt              <= cnt + 4'd1;
          end
        end
      end
      if (state == DONE) begin
        char_num   <= cnt;
        char_left  <= slot_l;
        char_right <= slot_r;
      end
    end
  end

`ifdef CHAR_SEG_OVERLAY_EN
  logic col_hit;
  always_comb begin
    col_hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < char_num &&
          (x_cnt == char_left[10*i +: 10] ||
           x_cnt == char_right[10*i +: 10]))
        col_hit = 1'b1;
    end
    ov_hit = per_frame_clken &&
             ((in_rows && col_hit) ||
              y_cnt == rt_eff || y_cnt == rb_eff);
  end
`else
  assign ov_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1               <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
    end else begin
      v1 <= {per_frame_vsync, per_frame_href,
             per_frame_clken, per_img_Bit | ov_hit};
      {post_frame_vsync, post_frame_href,
       post_frame_clken, post_img_Bit} <= v1;
    end
  end

endmodule

// File: tb/tb_vip_char_vertical_segment.sv
// Bench for vip_char_vertical_segment on a reduced 200x16 frame.
// Frame vectors feed a result scoreboard; video is checked at 2-cycle delay.
module tb_vip_char_vertical_segment;

  localparam int H   = 200;
  localparam int V   = 16;
  localparam int HBL = 6;

  typedef struct packed {
    logic [9:0]      rt;
    logic [9:0]      rb;
    logic [3:0]      nb;
    logic [9:0][9:0] bl;
    logic [9:0][9:0] br;
    int              spike;
    logic [3:0]      num;
    logic [7:0][9:0] el;
    logic [7:0][9:0] er;
  } vec_t;

  typedef struct packed {
    logic [3:0]  num;
    logic [79:0] l;
    logic [79:0] r;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs, hs, ce, px;
  logic [9:0]  row_top, row_bottom;
  logic        post_frame_vsync, post_frame_href;
  logic        post_frame_clken, post_img_Bit;
  logic [3:0]  char_num;
  logic [79:0] char_left, char_right;
  logic        seg_valid, seg_overrun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   sv_cnt = 0;
  int   or_cnt = 0;
  int   n_exp = 0;
  int   drv_row = 0;
  int   drv_col = 0;
  logic prev_sv = 1'b0;

  logic [3:0]  ov_num = '0;
  logic [79:0] ov_l = '0;
  logic [79:0] ov_r = '0;

  res_t       rq[$];
  logic [3:0] vq[$];
  logic [3:0] ve, vexp;
  res_t       got;
  vec_t       vt[7];

  vip_char_vertical_segment #(
    .IMG_HDISP(10'(H)),
    .IMG_VDISP(10'(V)),
    .COL_TH   (10'd2),
    .MIN_W    (10'd4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (vs),
    .per_frame_href  (hs),
    .per_frame_clken (ce),
    .per_img_Bit     (px),
    .row_top         (row_top),
    .row_bottom      (row_bottom),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_href (post_frame_href),
    .post_frame_clken(post_frame_clken),
    .post_img_Bit    (post_img_Bit),
    .char_num        (char_num),
    .char_left       (char_left),
    .char_right      (char_right),
    .seg_valid       (seg_valid),
    .seg_overrun     (seg_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ink(input vec_t v, input int r, input int c);
    logic b;
    b = 1'b0;
    if (r >= int'(v.rt) && r <= int'(v.rb)) begin
      for (int k = 0; k < int'(v.nb); k++)
        if (c >= int'(v.bl[k]) && c <= int'(v.br[k])) b = 1'b1;
      if (c == v.spike && r == int'(v.rt)) b = 1'b1;
    end else begin
      b = (c >= 120 && c <= 127);
    end
    return b;
  endfunction

  // video: what goes in at edge k must come out after edge k+1
  always @(posedge clk) begin
    ve = {vs, hs, ce, px};
`ifdef CHAR_SEG_OVERLAY_EN
    if (ce) begin
      logic hit, inr;
      inr = drv_row >= int'(row_top) && drv_row <= int'(row_bottom);
      hit = drv_row == int'(row_top) || drv_row == int'(row_bottom);
      for (int i = 0; i < 8; i++)
        if (i < int'(ov_num) &&
            (drv_col == int'(ov_l[10*i +: 10]) ||
             drv_col == int'(ov_r[10*i +: 10])))
          hit = hit | inr;
      ve[0] = ve[0] | hit;
    end
`endif
    if (!rst_n) begin
      vq.delete();
      vq.push_back(4'd0);
      #1;
      chk("post_reset", {post_frame_vsync, post_frame_href,
                         post_frame_clken, post_img_Bit}, 0);
    end else begin
      vq.push_back(ve);
      #1;
      if (vq.size() >= 2) begin
        vexp = vq.pop_front();
        chk("post_video", {post_frame_vsync, post_frame_href,
                           post_frame_clken, post_img_Bit}, vexp);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (prev_sv) chk("seg_valid_width", seg_valid, 0);
    prev_sv = seg_valid;
    if (seg_overrun) or_cnt++;
    if (seg_valid) begin
      sv_cnt++;
      if (rq.size() == 0) begin
        chk("seg_valid_spurious", seg_valid, 0);
      end else begin
        got = rq.pop_front();
        chk("char_num", char_num, got.num);
        chk("char_left", char_left, got.l);
        chk("char_right", char_right, got.r);
        chk("seg_valid_latency", cyc - fall_cyc, H + 2);
        ov_num = got.num;
        ov_l   = got.l;
        ov_r   = got.r;
      end
    end
  end

  task automatic drive_frame(input vec_t v, input int vbl, input bit want);
    res_t e;
    row_top = v.rt;
    row_bottom = v.rb;
    vs = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (4) @(negedge clk);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        hs = 1'b1;
        ce = 1'b1;
        px = ink(v, y, x);
        drv_row = y;
        drv_col = x;
        @(negedge clk);
      end
      hs = 1'b0;
      ce = 1'b0;
      px = 1'b0;
      if (y == V - 1) begin
        fall_cyc = cyc + 1;
        if (want) begin
          e.num = v.num;
          e.l   = v.el;
          e.r   = v.er;
          rq.push_back(e);
          n_exp++;
        end
        repeat (vbl) @(negedge clk);
      end else begin
        repeat (HBL) @(negedge clk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sv0, or0;
    foreach (vt[i]) begin
      vt[i] = '0;
      vt[i].spike = -1;
    end
    vt[0].rt = 4;  vt[0].rb = 11; vt[0].nb = 2;
    vt[0].bl[0] = 50; vt[0].br[0] = 59;
    vt[0].bl[1] = 80; vt[0].br[1] = 89;
    vt[0].num = 2;
    vt[0].el[0] = 50; vt[0].er[0] = 59;
    vt[0].el[1] = 80; vt[0].er[1] = 89;
    vt[1].rt = 2;  vt[1].rb = 13; vt[1].nb = 10;
    for (int k = 0; k < 10; k++) begin
      vt[1].bl[k] = 10'(10 + 20 * k);
      vt[1].br[k] = 10'(15 + 20 * k);
    end
    vt[1].num = 8;
    for (int k = 0; k < 8; k++) begin
      vt[1].el[k] = 10'(10 + 20 * k);
      vt[1].er[k] = 10'(15 + 20 * k);
    end
    vt[2].rt = 5;  vt[2].rb = 9; vt[2].nb = 2;
    vt[2].bl[0] = 5;   vt[2].br[0] = 7;
    vt[2].bl[1] = 160; vt[2].br[1] = 10'(H - 1);
    vt[2].num = 1;
    vt[2].el[0] = 160; vt[2].er[0] = 10'(H - 1);
    vt[3].rt = 3;  vt[3].rb = 12; vt[3].nb = 1;
    vt[3].bl[0] = 30; vt[3].br[0] = 39;
    vt[3].spike = 40;
    vt[3].num = 1;
    vt[3].el[0] = 30; vt[3].er[0] = 39;
    vt[4].rt = 12; vt[4].rb = 5; vt[4].nb = 1;
    vt[4].bl[0] = 50; vt[4].br[0] = 59;
    vt[5].rt = 6;  vt[5].rb = 8; vt[5].nb = 2;
    vt[5].bl[0] = 0;  vt[5].br[0] = 4;
    vt[5].bl[1] = 70; vt[5].br[1] = 73;
    vt[5].num = 2;
    vt[5].el[0] = 0;  vt[5].er[0] = 4;
    vt[5].el[1] = 70; vt[5].er[1] = 73;
    vt[6].rt = 7;  vt[6].rb = 7; vt[6].nb = 1;
    vt[6].bl[0] = 10; vt[6].br[0] = 19;

    rst_n = 1'b0;
    vs = 1'b0; hs = 1'b0; ce = 1'b0; px = 1'b0;
    row_top = '0; row_bottom = '0;
    repeat (3) @(negedge clk);
    chk("reset_char_num", char_num, 0);
    chk("reset_char_left", char_left, 0);
    chk("reset_char_right", char_right, 0);
    chk("reset_seg_valid", seg_valid, 0);
    chk("reset_seg_overrun", seg_overrun, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++)
      drive_frame(vt[i], H + 20, 1'b1);
    chk("no_overrun", or_cnt, 0);

    // next frame starts 100 cycles after the last line, inside the scan
    or0 = or_cnt;
    drive_frame(vt[1], 92, 1'b1);
    drive_frame(vt[0], H + 20, 1'b1);
    chk("overrun_pulses", or_cnt - or0, 1);

    // reset in the middle of the scan: no result for that frame
    drive_frame(vt[5], 0, 1'b0);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    ov_num = '0; ov_l = '0; ov_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midscan_char_num", char_num, 0);
    chk("midscan_char_left", char_left, 0);
    chk("midscan_char_right", char_right, 0);
    chk("midscan_seg_valid", seg_valid, 0);
    sv0 = sv_cnt;
    repeat (H + 20) @(negedge clk);
    chk("midscan_no_seg_valid", sv_cnt - sv0, 0);

    drive_frame(vt[0], H + 20, 1'b1);
    chk("results_pending", rq.size(), 0);
    chk("seg_valid_count", sv_cnt, n_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
